// File: rtl/pipeline_skid.sv
// Two-entry valid/ready register slice with registered forward and backward paths.
// Every output is a flop, so no input reaches an output combinationally.
module pipeline_skid #(
  parameter int unsigned width = 8,
  parameter int unsigned cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] data_out,
  output logic [1:0]       count,
  output logic [cnt_w-1:0] beats_out
);

  typedef enum logic [2:0] {
    EMPTY = 3'b001,
    BUSY  = 3'b010,
    FULL  = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         count_q, count_d;
  logic [width-1:0]   data_q, data_d;
  logic [width-1:0]   skid_q, skid_d;
  logic [cnt_w-1:0]   beats_q, beats_d;
  logic               push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
      data_q      <= '0;
      skid_q      <= '0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      data_q      <= data_d;
      skid_q      <= skid_d;
      beats_q     <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          data_d  = data_in;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (push && pop) begin
          data_d = data_in;
        end else if (push) begin
          skid_d  = data_in;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          data_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are decoded from the next state and registered,
  // so they always match state_q without any output-side logic.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    count_d     = 2'd0;
    case (state_d)
      BUSY: begin
        out_valid_d = 1'b1;
        count_d     = 2'd1;
      end
      FULL: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        count_d     = 2'd2;
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        count_d     = 2'd0;
      end
    endcase
  end

  always_comb begin
    beats_d = beats_q;
    if (pop) beats_d = beats_q + cnt_w'(1);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign data_out  = data_q;
  assign beats_out = beats_q;

endmodule

// File: tb/tb_pipeline_skid.sv
// Bench for pipeline_skid: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipeline_skid;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] data_in = '0;

  logic        in_ready, out_valid;
  logic [7:0]  data_out;
  logic [1:0]  count;
  logic [15:0] beats_out;

  logic        in_ready4, out_valid4;
  logic [7:0]  data_out4;
  logic [1:0]  count4;
  logic [3:0]  beats_out4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_skid #(.width(8), .cnt_w(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .count(count), .beats_out(beats_out)
  );

  pipeline_skid #(.width(8), .cnt_w(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .data_in(data_in),
    .out_valid(out_valid4), .out_ready(out_ready), .data_out(data_out4),
    .count(count4), .beats_out(beats_out4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of at most two beats; output shows the head,
  // or the last delivered beat once drained.
  logic [7:0]  m_q[$];
  logic [7:0]  m_last;
  int unsigned m_beats;
  logic        m_push, m_pop;

  initial begin
    m_last  = '0;
    m_beats = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_last  = '0;
        m_beats = 0;
      end else begin
        m_push = in_valid && (m_q.size() < 2);
        m_pop  = (m_q.size() > 0) && out_ready;
        if (m_pop) begin
          void'(m_q.pop_front());
          m_beats++;
        end
        if (m_push) m_q.push_back(data_in);
        if (m_q.size() > 0) m_last = m_q[0];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_out_valid", out_valid, m_q.size() > 0);
      chk("m_in_ready",  in_ready,  m_q.size() < 2);
      chk("m_count",     count,     m_q.size());
      chk("m_data_out",  data_out,  m_last);
      chk("m_beats",     beats_out, m_beats % 65536);
      chk("m4_out_valid", out_valid4, m_q.size() > 0);
      chk("m4_in_ready",  in_ready4,  m_q.size() < 2);
      chk("m4_count",     count4,     m_q.size());
      chk("m4_data_out",  data_out4,  m_last);
      chk("m4_beats",     beats_out4, m_beats % 16);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset then idle
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_beats", beats_out, 0);

    // streaming 0x01..0x10 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      in_valid = 1'b1;
      data_in = 8'(i);
      @(negedge clk);
      if (i > 1) begin
        chk("stream_data", data_out, 32'(i - 1));
        chk("stream_valid", out_valid, 1);
      end
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", data_out, 8'h10);
    tick();
    @(negedge clk);
    chk("stream_beats", beats_out, 16);
    chk("stream_drained", out_valid, 0);

    // back-pressure with 0xA0, 0xA1, 0xA2
    tick();
    in_valid = 1'b1; data_in = 8'hA0; out_ready = 1'b1;
    tick();
    data_in = 8'hA1; out_ready = 1'b0;
    tick();
    data_in = 8'hA2;
    @(negedge clk);
    chk("bp_count_full", count, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head", data_out, 8'hA0);
    tick();
    @(negedge clk);
    chk("bp_hold_data", data_out, 8'hA0);
    chk("bp_hold_count", count, 2);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_second", data_out, 8'hA1);
    chk("bp_in_ready_rise", in_ready, 1);
    chk("bp_count_busy", count, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third", data_out, 8'hA2);
    tick();
    @(negedge clk);
    chk("bp_empty", out_valid, 0);

    // simultaneous push and pop in BUSY
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1; data_in = 8'h55;
    tick();
    data_in = 8'h66; out_ready = 1'b1;
    @(negedge clk);
    chk("pp_hold55", data_out, 8'h55);
    chk("pp_count_a", count, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("pp_data66", data_out, 8'h66);
    chk("pp_count_b", count, 1);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("pp_drained", count, 0);

    // mid-operation reset from FULL
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1; data_in = 8'h11;
    tick();
    data_in = 8'h22;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr_full", count, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_count", count, 0);
    chk("mr_data_out", data_out, 8'h00);
    chk("mr_beats", beats_out, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("mr_no_beat", out_valid, 0);
    chk("mr_beats_after", beats_out, 0);

    // counter wrap on the 4-bit instance
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      in_valid = 1'b1;
      data_in = 8'(8'hC0 + i);
    end
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("wrap_beats4", beats_out4, 1);
    chk("wrap_beats16", beats_out, 17);
    chk("wrap_last", data_out, 8'hD0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
